// File: rtl/pulse_blinker_if.sv
// Event/LED bundle between pulse sources and pulse_blinker.
// The i_clear wire exists only when PULSE_BLINKER_CLEAR_EN is defined.
interface pulse_blinker_if #(
  parameter int PEND_W = 4
);
  logic              i_pulse;
`ifdef PULSE_BLINKER_CLEAR_EN
  logic              i_clear;
`endif
  logic              o_led;
  logic              o_busy;
  logic [PEND_W-1:0] o_pending;
  logic              o_overflow;

`ifdef PULSE_BLINKER_CLEAR_EN
  modport master (
    output i_pulse,
    output i_clear,
    input  o_led,
    input  o_busy,
    input  o_pending,
    input  o_overflow
  );

  modport slave (
    input  i_pulse,
    input  i_clear,
    output o_led,
    output o_busy,
    output o_pending,
    output o_overflow
  );
`else
  modport master (
    output i_pulse,
    input  o_led,
    input  o_busy,
    input  o_pending,
    input  o_overflow
  );

  modport slave (
    input  i_pulse,
    output o_led,
    output o_busy,
    output o_pending,
    output o_overflow
  );
`endif
endinterface

// File: rtl/pulse_blinker.sv
// Queues one-cycle event strobes and replays each as a tick-timed LED blink.
// Optional abort input i_clear is built when PULSE_BLINKER_CLEAR_EN is defined.
module pulse_blinker #(
  parameter int TICK_DIV    = 250000,
  parameter int ON_TICKS    = 2,
  parameter int OFF_TICKS   = 2,
  parameter int MAX_PENDING = 15,
  parameter int PEND_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  pulse_blinker_if.slave  bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_T = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t            state_r;
  logic [PRE_W-1:0]  prescaler_r;
  logic [CNT_W-1:0]  tick_cnt_r;
  logic [PEND_W-1:0] pending_r;
  logic              led_r;
  logic              busy_r;
  logic              overflow_r;

  logic              tick_s;
  logic              clear_s;
  logic              pend_nz_s;
  logic              at_max_s;
  logic              start_s;
  logic              inc_s;
  logic              dec_s;

`ifdef PULSE_BLINKER_CLEAR_EN
  assign clear_s = bus.i_clear;
`else
  assign clear_s = 1'b0;
`endif

  assign tick_s    = (prescaler_r == PRE_LAST);
  assign pend_nz_s = (pending_r != {PEND_W{1'b0}});
  assign at_max_s  = (pending_r == PEND_MAX);

  // Free-running tick prescaler; only rst restarts it, clear leaves the phase alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_r <= {PRE_W{1'b0}};
    end else if (tick_s) begin
      prescaler_r <= {PRE_W{1'b0}};
    end else begin
      prescaler_r <= prescaler_r + PRE_W'(1);
    end
  end

  // A blink starts on a tick when leaving IDLE or finishing the dark gap with work queued.
  always_comb begin
    start_s = 1'b0;
    if (tick_s && pend_nz_s) begin
      case (state_r)
        ST_IDLE: start_s = 1'b1;
        ST_OFF:  start_s = (tick_cnt_r == OFF_LAST);
        default: start_s = 1'b0;
      endcase
    end else begin
      start_s = 1'b0;
    end
  end

  // At saturation the increment is blocked even if a blink frees a slot this cycle.
  assign dec_s = start_s && !clear_s;
  assign inc_s = bus.i_pulse && !at_max_s && !clear_s;

  // Pending event counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {PEND_W{1'b0}};
    end else if (clear_s) begin
      pending_r <= {PEND_W{1'b0}};
    end else begin
      case ({inc_s, dec_s})
        2'b10:   pending_r <= pending_r + PEND_W'(1);
        2'b01:   pending_r <= pending_r - PEND_W'(1);
        default: pending_r <= pending_r;
      endcase
    end
  end

  // Drop strobe: any pulse arriving at saturation is lost, except one swallowed by clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= bus.i_pulse && at_max_s && !clear_s;
    end
  end

  // Blink sequencer; led_r/busy_r are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= {CNT_W{1'b0}};
      led_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else if (tick_s) begin
      case (state_r)
        ST_IDLE: begin
          if (pend_nz_s) begin
            state_r    <= ST_ON;
            tick_cnt_r <= {CNT_W{1'b0}};
            led_r      <= 1'b1;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= {CNT_W{1'b0}};
            led_r      <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        ST_ON: begin
          if (tick_cnt_r == ON_LAST) begin
            state_r    <= ST_OFF;
            tick_cnt_r <= {CNT_W{1'b0}};
            led_r      <= 1'b0;
          end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (tick_cnt_r == OFF_LAST) begin
            tick_cnt_r <= {CNT_W{1'b0}};
            if (pend_nz_s) begin
              state_r <= ST_ON;
              led_r   <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          tick_cnt_r <= {CNT_W{1'b0}};
          led_r      <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign bus.o_led      = led_r;
  assign bus.o_busy     = busy_r;
  assign bus.o_pending  = pending_r;
  assign bus.o_overflow = overflow_r;

endmodule

// File: tb/tb_pulse_blinker.sv
// Scoreboard bench for pulse_blinker: expected blinks are queued as stimulus is
// driven and matched by a monitor at each LED falling edge.
module tb_pulse_blinker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  typedef struct {
    int start;
    int len;
  } blink_t;

  blink_t sb_q[$];
  blink_t mon_exp;
  logic   led_prev = 1'b0;
  int     rise_cyc = 0;

  pulse_blinker_if #(.PEND_W(2)) bif ();

  pulse_blinker #(
    .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1), .MAX_PENDING(3), .PEND_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: on every LED fall, pop one expected blink and compare start and length.
  always @(negedge clk) begin
    if (bif.o_led === 1'b1 && !led_prev) rise_cyc = cyc;
    if (bif.o_led !== 1'b1 && led_prev) begin
      chk_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL blink_unexpected: got start=%0d len=%0d, expected no blink", rise_cyc, cyc - rise_cyc);
      end else begin
        mon_exp = sb_q.pop_front();
        if (rise_cyc !== mon_exp.start || (cyc - rise_cyc) !== mon_exp.len)
          $display("FAIL blink: got start=%0d len=%0d, expected start=%0d len=%0d",
                   rise_cyc, cyc - rise_cyc, mon_exp.start, mon_exp.len);
        else
          pass_cnt++;
      end
    end
    led_prev = (bif.o_led === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_blink(input int rel_start, input int len);
    blink_t b;
    b.start = base + rel_start;
    b.len   = len;
    sb_q.push_back(b);
  endtask

  // Advance to the negedge inside cycle k counted from the last reset release.
  task automatic goto(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bif.i_pulse = 1'b0;
`ifdef PULSE_BLINKER_CLEAR_EN
    bif.i_clear = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic test_reset();
    logic any_led, any_busy, any_ovf;
    logic [1:0] pend_or;
    any_led = 1'b0; any_busy = 1'b0; any_ovf = 1'b0; pend_or = 2'b00;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      goto(i);
      any_led  = any_led  | (bif.o_led !== 1'b0);
      any_busy = any_busy | (bif.o_busy !== 1'b0);
      any_ovf  = any_ovf  | (bif.o_overflow !== 1'b0);
      pend_or  = pend_or  | bif.o_pending;
    end
    chk_cnt++; if (any_led !== 1'b0) $display("FAIL reset_led: got %b, expected 0", any_led); else pass_cnt++;
    chk_cnt++; if (any_busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", any_busy); else pass_cnt++;
    chk_cnt++; if (any_ovf !== 1'b0) $display("FAIL reset_ovf: got %b, expected 0", any_ovf); else pass_cnt++;
    chk_cnt++; if (pend_or !== 2'd0) $display("FAIL reset_pending: got %0d, expected 0", pend_or); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    bif.i_pulse = 1'b1;
    push_blink(4, 8);
    goto(1); bif.i_pulse = 1'b0;
    chk_cnt++; if (bif.o_pending !== 2'd1) $display("FAIL single_pend1: got %0d, expected 1", bif.o_pending); else pass_cnt++;
    goto(3);
    chk_cnt++; if (bif.o_led !== 1'b0) $display("FAIL single_led_pre: got %b, expected 0", bif.o_led); else pass_cnt++;
    goto(4);
    chk_cnt++; if (bif.o_pending !== 2'd0) $display("FAIL single_pend0: got %0d, expected 0", bif.o_pending); else pass_cnt++;
    chk_cnt++; if (bif.o_busy !== 1'b1) $display("FAIL single_busy_on: got %b, expected 1", bif.o_busy); else pass_cnt++;
    goto(15);
    chk_cnt++; if (bif.o_busy !== 1'b1 || bif.o_led !== 1'b0) $display("FAIL single_dark: got busy=%b led=%b, expected busy=1 led=0", bif.o_busy, bif.o_led); else pass_cnt++;
    goto(16);
    chk_cnt++; if (bif.o_busy !== 1'b0) $display("FAIL single_idle: got %b, expected 0", bif.o_busy); else pass_cnt++;
    chk_cnt++; if (sb_q.size() !== 0) $display("FAIL single_drain: got %0d left, expected 0", sb_q.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic gap;
    gap = 1'b0;
    do_reset();
    push_blink(4, 8);
    push_blink(16, 8);
    bif.i_pulse = 1'b1;
    goto(1); bif.i_pulse = 1'b1;
    goto(2); bif.i_pulse = 1'b0;
    chk_cnt++; if (bif.o_pending !== 2'd2) $display("FAIL b2b_pend2: got %0d, expected 2", bif.o_pending); else pass_cnt++;
    for (int k = 4; k < 28; k++) begin
      goto(k);
      gap = gap | (bif.o_busy !== 1'b1);
    end
    chk_cnt++; if (gap !== 1'b0) $display("FAIL b2b_busy_gap: got %b, expected 0", gap); else pass_cnt++;
    goto(28);
    chk_cnt++; if (bif.o_busy !== 1'b0) $display("FAIL b2b_idle: got %b, expected 0", bif.o_busy); else pass_cnt++;
    chk_cnt++; if (sb_q.size() !== 0) $display("FAIL b2b_drain: got %0d left, expected 0", sb_q.size()); else pass_cnt++;
  endtask

  task automatic test_saturate();
    int ovf_n;
    logic [1:0] pend6, pend7, pend8;
    logic busy43;
    ovf_n = 0; pend6 = '0; pend7 = '0; pend8 = '0; busy43 = 1'b0;
    do_reset();
    push_blink(8, 8);
    push_blink(20, 8);
    push_blink(32, 8);
    for (int k = 3; k <= 44; k++) begin
      goto(k);
      if (bif.o_overflow === 1'b1) ovf_n++;
      if (k == 6) pend6 = bif.o_pending;
      if (k == 7) pend7 = bif.o_pending;
      if (k == 8) pend8 = bif.o_pending;
      if (k == 43) busy43 = bif.o_busy;
      bif.i_pulse = (k <= 7);
    end
    chk_cnt++; if (pend6 !== 2'd3 || pend7 !== 2'd3) $display("FAIL sat_pend: got %0d/%0d, expected 3/3", pend6, pend7); else pass_cnt++;
    chk_cnt++; if (pend8 !== 2'd2) $display("FAIL sat_dec_at_max: got %0d, expected 2", pend8); else pass_cnt++;
    chk_cnt++; if (ovf_n !== 2) $display("FAIL sat_ovf_count: got %0d, expected 2", ovf_n); else pass_cnt++;
    chk_cnt++; if (busy43 !== 1'b1 || bif.o_busy !== 1'b0) $display("FAIL sat_end: got busy43=%b busy44=%b, expected 1/0", busy43, bif.o_busy); else pass_cnt++;
    chk_cnt++; if (sb_q.size() !== 0) $display("FAIL sat_drain: got %0d left, expected 0", sb_q.size()); else pass_cnt++;
  endtask

  task automatic test_pulse_on_start();
    do_reset();
    push_blink(4, 8);
    push_blink(16, 8);
    bif.i_pulse = 1'b1;
    goto(1); bif.i_pulse = 1'b0;
    goto(3); bif.i_pulse = 1'b1;
    goto(4); bif.i_pulse = 1'b0;
    chk_cnt++; if (bif.o_pending !== 2'd1) $display("FAIL pos_pend_hold: got %0d, expected 1", bif.o_pending); else pass_cnt++;
    chk_cnt++; if (bif.o_overflow !== 1'b0) $display("FAIL pos_ovf: got %b, expected 0", bif.o_overflow); else pass_cnt++;
    goto(16);
    chk_cnt++; if (bif.o_pending !== 2'd0) $display("FAIL pos_pend_second: got %0d, expected 0", bif.o_pending); else pass_cnt++;
    goto(28);
    chk_cnt++; if (bif.o_busy !== 1'b0) $display("FAIL pos_idle: got %b, expected 0", bif.o_busy); else pass_cnt++;
    chk_cnt++; if (sb_q.size() !== 0) $display("FAIL pos_drain: got %0d left, expected 0", sb_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_blink(4, 3);
    bif.i_pulse = 1'b1;
    goto(3); bif.i_pulse = 1'b0;
    goto(6);
    chk_cnt++; if (bif.o_led !== 1'b1 || bif.o_pending !== 2'd2) $display("FAIL rmid_pre: got led=%b pend=%0d, expected 1/2", bif.o_led, bif.o_pending); else pass_cnt++;
    rst = 1'b1;
    goto(7);
    rst = 1'b0;
    chk_cnt++; if (bif.o_led !== 1'b0 || bif.o_pending !== 2'd0 || bif.o_busy !== 1'b0)
      $display("FAIL rmid_post: got led=%b pend=%0d busy=%b, expected 0/0/0", bif.o_led, bif.o_pending, bif.o_busy);
    else pass_cnt++;
    base = cyc;
    push_blink(4, 8);
    bif.i_pulse = 1'b1;
    goto(1); bif.i_pulse = 1'b0;
    goto(3);
    chk_cnt++; if (bif.o_led !== 1'b0 || bif.o_pending !== 2'd1) $display("FAIL rmid_phase: got led=%b pend=%0d, expected 0/1", bif.o_led, bif.o_pending); else pass_cnt++;
    goto(16);
    chk_cnt++; if (bif.o_busy !== 1'b0) $display("FAIL rmid_idle: got %b, expected 0", bif.o_busy); else pass_cnt++;
    chk_cnt++; if (sb_q.size() !== 0) $display("FAIL rmid_drain: got %0d left, expected 0", sb_q.size()); else pass_cnt++;
  endtask

`ifdef PULSE_BLINKER_CLEAR_EN
  task automatic test_clear();
    do_reset();
    push_blink(4, 3);
    bif.i_pulse = 1'b1;
    goto(2); bif.i_pulse = 1'b0;
    goto(6);
    chk_cnt++; if (bif.o_led !== 1'b1 || bif.o_pending !== 2'd1) $display("FAIL clr_pre: got led=%b pend=%0d, expected 1/1", bif.o_led, bif.o_pending); else pass_cnt++;
    bif.i_clear = 1'b1;
    bif.i_pulse = 1'b1;
    goto(7);
    bif.i_clear = 1'b0;
    chk_cnt++; if (bif.o_led !== 1'b0 || bif.o_pending !== 2'd0 || bif.o_overflow !== 1'b0 || bif.o_busy !== 1'b0)
      $display("FAIL clr_post: got led=%b pend=%0d ovf=%b busy=%b, expected 0/0/0/0", bif.o_led, bif.o_pending, bif.o_overflow, bif.o_busy);
    else pass_cnt++;
    push_blink(12, 8);
    goto(8); bif.i_pulse = 1'b0;
    chk_cnt++; if (bif.o_pending !== 2'd1) $display("FAIL clr_pend_after: got %0d, expected 1", bif.o_pending); else pass_cnt++;
    goto(24);
    chk_cnt++; if (bif.o_busy !== 1'b0) $display("FAIL clr_idle: got %b, expected 0", bif.o_busy); else pass_cnt++;
    chk_cnt++; if (sb_q.size() !== 0) $display("FAIL clr_drain: got %0d left, expected 0", sb_q.size()); else pass_cnt++;
  endtask
`endif

  initial begin
    bif.i_pulse = 1'b0;
`ifdef PULSE_BLINKER_CLEAR_EN
    bif.i_clear = 1'b0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_pulse_on_start();
    test_reset_mid();
`ifdef PULSE_BLINKER_CLEAR_EN
    test_clear();
`endif
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pulse_blinker.md
Name: pulse_blinker

Overview:
Converts one-cycle event pulses, such as button-press strobes, into human-visible LED blinks. Each input pulse is queued as a pending event. Events are replayed one at a time as an ON/OFF blink whose timing is measured in slow ticks from an internal prescaler. The block sits between event sources and the matrix/status LED drivers.

Parameters:
TICK_DIV, 250000, clocks per tick; tick period = TICK_DIV clk cycles; must be >= 1.
ON_TICKS, 2, ticks the LED stays lit per blink; must be >= 1.
OFF_TICKS, 2, dark gap in ticks after each blink; must be >= 1.
MAX_PENDING, 15, saturation limit of the event queue; must be >= 1 and <= 2^PEND_W-1.
PEND_W, 4, width of the pending counter.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
i_pulse  input  1  event strobe; each cycle it is high counts as one event.
o_led  output  1  blink output; high only while in ON state.
o_busy  output  1  high when state != IDLE.
o_pending  output  PEND_W  current queued event count.
o_overflow  output  1  one-cycle strobe when an event is dropped at saturation.

Behaviour:
- Reset: all registers clear in the same cycle. prescaler=0, tick_cnt=0, pending=0, state=IDLE. o_led, o_busy and o_overflow are 0 in the cycle after rst is sampled high. rst overrides all other inputs.
- Prescaler: free-running counter 0..TICK_DIV-1 that wraps to 0. Internal tick is high in the cycle where prescaler==TICK_DIV-1. TICK_DIV=1 gives a tick every cycle.
- Pending counter:
  - inc = i_pulse && pending != MAX_PENDING.
  - dec = a blink starts this cycle.
  - inc && dec: pending unchanged.
  - i_pulse while pending==MAX_PENDING and no dec: pending holds; o_overflow=1 next cycle.
  - i_pulse at MAX_PENDING with a simultaneous dec: inc is blocked (dec only), and o_overflow still pulses; pending goes to MAX_PENDING-1.
- FSM, with states IDLE, ON, OFF. Transitions are evaluated only on tick cycles and use the registered pending value:
  - IDLE: tick && pending!=0 -> ON, dec, tick_cnt=0.
  - ON: on each tick, tick_cnt++. At tick with tick_cnt==ON_TICKS-1 -> OFF, tick_cnt=0.
  - OFF: on each tick, tick_cnt++. At tick with tick_cnt==OFF_TICKS-1:
    - pending!=0 -> ON, dec, tick_cnt=0 (back-to-back blinks without passing through IDLE);
    - otherwise -> IDLE.
- Outputs are Moore, decoded from the state register: o_led=(state==ON), o_busy=(state!=IDLE). o_pending is the pending register.
- Latency: a pulse at cycle t gives pending=1 at t+1. The blink starts at the first tick at or after t+1, and o_led rises the cycle after that tick. Each blink lasts exactly ON_TICKS*TICK_DIV cycles lit and OFF_TICKS*TICK_DIV cycles dark.
- A held-high i_pulse counts one event per cycle; sources must provide one-cycle strobes.
- Reset mid-blink: o_led drops the next cycle, the queue is emptied, and the prescaler restarts from 0.

Optional Feature:
PULSE_BLINKER_CLEAR_EN
- Defined: adds port i_clear (input, 1 bit). When i_clear is high, the next cycle has pending=0, state=IDLE and tick_cnt=0, aborting any blink so o_led=0 next cycle. The prescaler is not reset. i_clear has priority over a same-cycle i_pulse, which is discarded with no overflow.
- Undefined: port and logic are absent; the only way to drain the queue is blinking it out.

Test Plan:
All scenarios use TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1, MAX_PENDING=3, PEND_W=2.
- Reset then idle 40 cycles -> o_led=0, o_busy=0, o_pending=0, o_overflow never high.
- Single pulse at prescaler=0 -> o_pending=1 the next cycle. At the tick (prescaler=3) it returns to 0 and state goes ON. o_led is high for exactly 8 cycles, low for 4, then o_busy=0.
- Two pulses on consecutive cycles -> o_pending=2. Two blinks run back-to-back: 8 lit, 4 dark, 8 lit. o_busy stays high throughout, with no IDLE gap between blinks.
- Five consecutive pulse cycles while idle and pending=0 -> o_pending saturates at 3. o_overflow pulses on exactly 2 cycles. Three blinks are emitted in total.
- Pulse on the same cycle a queued blink starts, with pending=1 -> pending stays 1, then a second blink follows.
- rst asserted mid-ON with pending=2 -> the next cycle has o_led=0, o_pending=0, o_busy=0. The first blink after a new pulse starts at prescaler=3.
- With PULSE_BLINKER_CLEAR_EN defined: i_clear and i_pulse high together mid-blink -> o_led=0 and o_pending=0 the next cycle, with no overflow.
